execute_mdu: RTL



---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_divstep.sv | 18 +
 rtl/execute_mdu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;

    // Which result the FIX state writes back to HI/LO.
    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_MUL  = 2'd1;
    localparam logic [1:0] MODE_DIV  = 2'd2;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide step: trial-subtract the divisor from the shifted
// partial remainder and produce the next remainder plus one quotient bit.
module mdu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_c,
    output logic             q_bit_c
);

    // The kept remainder is always below the divisor, so WIDTH bits suffice.
    always_comb begin
        q_bit_c = (rem_in >= {1'b0, divisor});
        rem_c   = q_bit_c ? WIDTH'(rem_in - {1'b0, divisor}) : rem_in[WIDTH-1:0];
    end

endmodule

// File: rtl/execute_mdu.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise div/divu only flag div_zero.
module execute_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Function_opcode,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
    localparam logic [2:0] S_MUL  = 3'(ST_MUL);
    localparam logic [2:0] S_DIV  = 3'(ST_DIV);
    localparam logic [2:0] S_FIX  = 3'(ST_FIX);
    localparam logic [2:0] S_DONE = 3'(ST_DONE);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_lo_q, neg_lo_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] prod;

`ifdef MDU_DIV_EN
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] step_rem_c;
    logic             step_q_c;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  ({rem_q, acc_q[WIDTH-1]}),
        .divisor (mcand_q),
        .rem_c   (step_rem_c),
        .q_bit_c (step_q_c)
    );
`endif

    // Operand magnitudes and signs; unsigned ops never see a negative operand.
    always_comb begin
        op_signed = (Function_opcode == FUNCT_MULT) || (Function_opcode == FUNCT_DIV);
        a_neg     = op_signed & Read_data_1[WIDTH-1];
        b_neg     = op_signed & Read_data_2[WIDTH-1];
        a_mag     = a_neg ? (~Read_data_1) + WIDTH'(1) : Read_data_1;
        b_mag     = b_neg ? (~Read_data_2) + WIDTH'(1) : Read_data_2;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        neg_lo_d   = neg_lo_q;
        mode_d     = mode_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
`ifdef MDU_DIV_EN
        neg_hi_d   = neg_hi_q;
        rem_d      = rem_q;
`endif
        mul_sum = acc_q[0] ? ({1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, mcand_q})
                           : {1'b0, acc_q[ACC_W-1:WIDTH]};
        prod    = neg_lo_q ? (~acc_q) + ACC_W'(1) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (Function_opcode)
                        FUNCT_MTHI: begin
                            hi_d       = Read_data_1;
                            div_zero_d = 1'b0;
                        end
                        FUNCT_MTLO: begin
                            lo_d       = Read_data_1;
                            div_zero_d = 1'b0;
                        end
                        FUNCT_MULT, FUNCT_MULTU: begin
                            acc_d      = {WIDTH'(0), b_mag};
                            mcand_d    = a_mag;
                            neg_lo_d   = a_neg ^ b_neg;
                            mode_d     = MODE_MUL;
                            cnt_d      = CNT_W'(WIDTH);
                            div_zero_d = 1'b0;
                            state_d    = S_MUL;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
`ifdef MDU_DIV_EN
                            mode_d = MODE_DIV;
                            if (Read_data_2 == '0) begin
                                // FIX then writes HI = dividend, LO = all ones.
                                acc_d      = {WIDTH'(0), {WIDTH{1'b1}}};
                                rem_d      = Read_data_1;
                                neg_lo_d   = 1'b0;
                                neg_hi_d   = 1'b0;
                                div_zero_d = 1'b1;
                                state_d    = S_FIX;
                            end else begin
                                acc_d      = {WIDTH'(0), a_mag};
                                rem_d      = '0;
                                mcand_d    = b_mag;
                                neg_lo_d   = a_neg ^ b_neg;
                                neg_hi_d   = a_neg;
                                cnt_d      = CNT_W'(WIDTH);
                                div_zero_d = 1'b0;
                                state_d    = S_DIV;
                            end
`else
                            mode_d     = MODE_NONE;
                            div_zero_d = 1'b1;
                            state_d    = S_FIX;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                // Low half shifts the dividend out and the quotient in.
                acc_d = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-2:0], step_q_c};
                rem_d = step_rem_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
`endif
            S_FIX: begin
                case (mode_q)
                    MODE_MUL: begin
                        hi_d = prod[ACC_W-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
`ifdef MDU_DIV_EN
                    MODE_DIV: begin
                        lo_d = neg_lo_q ? (~acc_q[WIDTH-1:0]) + WIDTH'(1) : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? (~rem_q) + WIDTH'(1) : rem_q;
                    end
`endif
                    default: ;
                endcase
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            neg_lo_q   <= 1'b0;
            mode_q     <= MODE_NONE;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MDU_DIV_EN
            neg_hi_q   <= 1'b0;
            rem_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            neg_lo_q   <= neg_lo_d;
            mode_q     <= mode_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MDU_DIV_EN
            neg_hi_q   <= neg_hi_d;
            rem_q      <= rem_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule
